// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with a valid/ready input handshake and a
// 2-deep output buffer (main register O + skid register S).
//
// Ports:
//   clk, reset          core clock (rising edge), async active-high reset
//   flush               synchronous kill of every buffered op
//   in_valid/in_ready   upstream handshake; in_ready comes straight from a flop
//   ALUControl          000 add, 001 sub, 010 and, 011 or, 101 slt, others illegal
//   SrcA, SrcB          operands
//   RdIn, RegWriteIn    writeback tags carried alongside the result
//   out_valid/out_ready downstream handshake toward the MEM stage
//   ALUResult, Zero     result and its zero flag
//   RdOut, RegWriteOut  passthrough tags (RegWriteOut forced low on illegal op)
//   IllegalOp           the presented op had an illegal ALUControl code
module alu_exec_unit #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned RDW  = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      ALUControl,
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   input  logic [RDW-1:0]  RdIn,
   input  logic            RegWriteIn,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] ALUResult,
   output logic            Zero,
   output logic [RDW-1:0]  RdOut,
   output logic            RegWriteOut,
   output logic            IllegalOp
);

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] result;
      logic            zero;
      logic [RDW-1:0]  rd;
      logic            regwrite;
      logic            illegal;
   } op_t;

   localparam op_t OpReset = '{
      valid:    1'b0,
      result:   '0,
      zero:     1'b1,
      rd:       '0,
      regwrite: 1'b0,
      illegal:  1'b0
   };

   op_t o_q, o_d;
   op_t s_q, s_d;
   op_t new_op;

   logic acc;
   logic drn;

   // Skid occupancy is a flop, so downstream stalls never reach upstream combinationally.
   assign in_ready = ~s_q.valid;
   assign acc      = in_valid & in_ready;
   assign drn      = o_q.valid & out_ready;

   // Result is formed from the live inputs and captured on the accepting edge.
   always_comb begin
      logic [XLEN-1:0] res;
      logic            ill;
      res = '0;
      ill = 1'b0;
      case (ALUControl)
         3'b000:  res = SrcA + SrcB;
         3'b001:  res = SrcA - SrcB;
         3'b010:  res = SrcA & SrcB;
         3'b011:  res = SrcA | SrcB;
         3'b101:  res = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         default: begin
            res = '0;
            ill = 1'b1;
         end
      endcase
      new_op          = OpReset;
      new_op.valid    = 1'b1;
      new_op.result   = res;
      new_op.zero     = (res == '0);
      new_op.rd       = RdIn;
      new_op.regwrite = RegWriteIn & ~ill;
      new_op.illegal  = ill;
   end

   always_comb begin
      o_d = o_q;
      s_d = s_q;
      if (flush) begin
         // Flush wins over both accept and drain; payload bits are don't-care once invalid.
         o_d.valid = 1'b0;
         s_d.valid = 1'b0;
      end else if (!o_q.valid || drn) begin
         if (s_q.valid) begin
            o_d = s_q;
            if (acc) begin
               s_d = new_op;
            end else begin
               s_d.valid = 1'b0;
            end
         end else if (acc) begin
            o_d = new_op;
         end else begin
            o_d.valid = 1'b0;
         end
      end else if (acc) begin
         // O stalled: park the new op in the skid; in_ready falls next cycle.
         s_d = new_op;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_q <= OpReset;
         s_q <= OpReset;
      end else begin
         o_q <= o_d;
         s_q <= s_d;
      end
   end

   assign out_valid   = o_q.valid;
   assign ALUResult   = o_q.result;
   assign Zero        = o_q.zero;
   assign RdOut       = o_q.rd;
   assign RegWriteOut = o_q.regwrite;
   assign IllegalOp   = o_q.illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed-vector bench for alu_exec_unit. The stimulus side
// pushes the hand-computed expected response when an op is accepted; a monitor
// pops and compares whenever the DUT hands a result downstream.
module tb_alu_exec_unit;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  ALUControl;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic [4:0]  RdIn;
   logic        RegWriteIn;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ALUResult;
   logic        Zero;
   logic [4:0]  RdOut;
   logic        RegWriteOut;
   logic        IllegalOp;

   alu_exec_unit #(
      .XLEN(32),
      .RDW (5)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ALUControl (ALUControl),
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .RdIn       (RdIn),
      .RegWriteIn (RegWriteIn),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ALUResult  (ALUResult),
      .Zero       (Zero),
      .RdOut      (RdOut),
      .RegWriteOut(RegWriteOut),
      .IllegalOp  (IllegalOp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        rw;
      logic        ill;
      int          acc_cyc;
      bit          lat;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: results must leave in issue order, carrying their tags.
   always @(negedge clk) begin
      if (!reset) begin
         if (out_ready && q.size() > 0) check("no_gap", {31'b0, out_valid}, 32'd1);
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_output: got result %h with nothing expected", ALUResult);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("result", ALUResult, e.res);
               check("zero", {31'b0, Zero}, {31'b0, (e.res == 32'd0)});
               check("rd", {27'b0, RdOut}, {27'b0, e.rd});
               check("regwrite", {31'b0, RegWriteOut}, {31'b0, e.rw});
               check("illegal", {31'b0, IllegalOp}, {31'b0, e.ill});
               if (e.lat) check("latency", cyc, e.acc_cyc + 1);
            end
         end
      end
   end

   // Offer one op; wait (bounded) for acceptance, then record its expected response.
   task automatic send(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic rw, input logic [31:0] res,
                       input bit lat);
      int   n;
      bit   ok;
      exp_t e;
      logic ill;
      n  = 0;
      ok = 1'b0;
      in_valid   = 1'b1;
      ALUControl = c;
      SrcA       = a;
      SrcB       = b;
      RdIn       = rd;
      RegWriteIn = rw;
      while (!ok && n < 50) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         n++;
      end
      if (ok) begin
         ill       = (c == 3'b100) || (c == 3'b110) || (c == 3'b111);
         e.res     = res;
         e.rd      = rd;
         e.rw      = rw & ~ill;
         e.ill     = ill;
         e.acc_cyc = cyc;
         e.lat     = lat;
         q.push_back(e);
      end else begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: got in_ready 0 for 50 cycles expected 1");
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("drain", q.size(), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish within 200000 time units");
      $fatal(1);
   end

   initial begin
      reset      = 1'b1;
      flush      = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      ALUControl = 3'b000;
      SrcA       = '0;
      SrcB       = '0;
      RdIn       = '0;
      RegWriteIn = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_result", ALUResult, 32'd0);
      check("rst_zero", {31'b0, Zero}, 32'd1);
      check("rst_rd", {27'b0, RdOut}, 32'd0);
      check("rst_regwrite", {31'b0, RegWriteOut}, 32'd0);
      check("rst_illegal", {31'b0, IllegalOp}, 32'd0);

      // Arithmetic and slt boundaries, streaming with out_ready high.
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 5'd1, 1'b1, 32'h8000_0000, 1'b1);
      send(3'b001, 32'h0000_0005, 32'h0000_0005, 5'd2, 1'b1, 32'h0000_0000, 1'b1);
      send(3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd3, 1'b0, 32'h00F0_00F0, 1'b1);
      send(3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd4, 1'b1, 32'hFFF0_FFF0, 1'b1);
      send(3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 5'd5, 1'b1, 32'h0000_0001, 1'b1);
      send(3'b101, 32'h0000_0001, 32'hFFFF_FFFF, 5'd6, 1'b1, 32'h0000_0000, 1'b1);
      send(3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 5'd7, 1'b1, 32'h0000_0001, 1'b1);
      send(3'b101, 32'h0000_1234, 32'h0000_1234, 5'd8, 1'b1, 32'h0000_0000, 1'b1);
      send(3'b110, 32'h1234_5678, 32'h1111_1111, 5'd9, 1'b1, 32'h0000_0000, 1'b1);
      send(3'b100, 32'hDEAD_BEEF, 32'h0000_0001, 5'd10, 1'b1, 32'h0000_0000, 1'b1);
      send(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 1'b0, 32'h0000_0000, 1'b1);
      drain();

      // Back-pressure: two ops fill O and S, the third waits upstream.
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(3'b000, 32'd1, 32'd2, 5'd12, 1'b1, 32'd3, 1'b0);
      send(3'b001, 32'd10, 32'd3, 5'd13, 1'b1, 32'd7, 1'b0);
      in_valid   = 1'b1;
      ALUControl = 3'b011;
      SrcA       = 32'h00FF_0000;
      SrcB       = 32'h0000_FF00;
      RdIn       = 5'd14;
      RegWriteIn = 1'b1;
      @(negedge clk);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_hold_result", ALUResult, 32'd3);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp_in_ready2", {31'b0, in_ready}, 32'd0);
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_hold_result2", ALUResult, 32'd3);
      check("bp_hold_rd", {27'b0, RdOut}, 32'd12);
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(3'b011, 32'h00FF_0000, 32'h0000_FF00, 5'd14, 1'b1, 32'h00FF_FF00, 1'b0);
      drain();

      // Flush with O and S full and a third op presented on the flush edge.
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(3'b000, 32'd100, 32'd1, 5'd15, 1'b1, 32'd101, 1'b0);
      send(3'b000, 32'd200, 32'd2, 5'd16, 1'b1, 32'd202, 1'b0);
      in_valid   = 1'b1;
      flush      = 1'b1;
      ALUControl = 3'b000;
      SrcA       = 32'd300;
      SrcB       = 32'd3;
      RdIn       = 5'd17;
      @(posedge clk);
      q.delete();
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("flush_out_valid", {31'b0, out_valid}, 32'd0);
      check("flush_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(3'b000, 32'd4, 32'd4, 5'd18, 1'b1, 32'd8, 1'b1);
      drain();

      // Asynchronous reset mid-stream with O and S full.
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(3'b000, 32'd5, 32'd6, 5'd19, 1'b1, 32'd11, 1'b0);
      send(3'b011, 32'hA, 32'h5, 5'd20, 1'b1, 32'hF, 1'b0);
      #2;
      reset = 1'b1;
      q.delete();
      @(negedge clk);
      check("mrst_out_valid", {31'b0, out_valid}, 32'd0);
      check("mrst_in_ready", {31'b0, in_ready}, 32'd1);
      check("mrst_result", ALUResult, 32'd0);
      check("mrst_zero", {31'b0, Zero}, 32'd1);
      @(posedge clk);
      #1;
      reset     = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("mrst_out_valid2", {31'b0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      send(3'b001, 32'd3, 32'd5, 5'd21, 1'b1, 32'hFFFF_FFFE, 1'b1);
      drain();

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
